csr_unit: RTL

CSR_UNIT -- requirements
Module: csr_unit

---
 rtl/csr_pkg.sv | 45 ++++
 rtl/csr_unit_if.sv | 24 ++
 rtl/csr_counter64.sv | 30 +++
 rtl/csr_unit.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR unit: addresses, access op encoding
// and the architectural bit positions of mstatus, mie and mip.
package csr_pkg;

  localparam int CSR_OP_W = 2;

  typedef enum logic [CSR_OP_W-1:0] {
    CSR_OP_READ  = 2'b00,
    CSR_OP_WRITE = 2'b01,
    CSR_OP_SET   = 2'b10,
    CSR_OP_CLEAR = 2'b11
  } csr_op_e;

  localparam logic [11:0] CSR_MSTATUS       = 12'h300;
  localparam logic [11:0] CSR_MISA          = 12'h301;
  localparam logic [11:0] CSR_MIE           = 12'h304;
  localparam logic [11:0] CSR_MTVEC         = 12'h305;
  localparam logic [11:0] CSR_MCOUNTEREN    = 12'h306;
  localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] CSR_MEPC          = 12'h341;
  localparam logic [11:0] CSR_MCAUSE        = 12'h342;
  localparam logic [11:0] CSR_MIP           = 12'h344;
  localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
  localparam logic [11:0] CSR_MVENDORID     = 12'hF11;
  localparam logic [11:0] CSR_MARCHID       = 12'hF12;
  localparam logic [11:0] CSR_MIMPID        = 12'hF13;
  localparam logic [11:0] CSR_MHARTID       = 12'hF14;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  localparam int MIE_MTIE = 7;
  localparam int MIE_MEIE = 11;
  localparam int MIP_MTIP = 7;
  localparam int MIP_MEIP = 11;

  localparam int MCNTINH_CY = 0;
  localparam int MCNTINH_IR = 2;

endpackage

// File: rtl/csr_unit_if.sv
// CSR access bus between the pipeline (master) and the CSR unit (slave).
interface csr_unit_if
  import csr_pkg::*;
#(
  parameter int XLEN = 32
);
  logic                csr_en_i;
  logic [CSR_OP_W-1:0] csr_op_i;
  logic [11:0]         csr_addr_i;
  logic [XLEN-1:0]     csr_wdata_i;
  logic [XLEN-1:0]     csr_rdata_o;
  logic                csr_valid_o;
  logic                csr_illegal_o;

  modport master (
    output csr_en_i, csr_op_i, csr_addr_i, csr_wdata_i,
    input  csr_rdata_o, csr_valid_o, csr_illegal_o
  );

  modport slave (
    input  csr_en_i, csr_op_i, csr_addr_i, csr_wdata_i,
    output csr_rdata_o, csr_valid_o, csr_illegal_o
  );
endinterface

// File: rtl/csr_counter64.sv
// 64-bit event counter with inhibit and independently writable 32-bit halves.
module csr_counter64 (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        inhibit_i,
  input  logic        inc_i,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic [31:0] wdata_lo_i,
  input  logic [31:0] wdata_hi_i,
  output logic [63:0] count_o
);

  logic [63:0] count_q;

  // Any write suppresses the increment for that cycle, so no carry leaks out of a written low half.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (wr_lo_i || wr_hi_i) begin
      if (wr_lo_i) count_q[31:0]  <= wdata_lo_i;
      if (wr_hi_i) count_q[63:32] <= wdata_hi_i;
    end else if (inc_i && !inhibit_i) begin
      count_q <= count_q + 64'd1;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR file: single-cycle read-modify-write access port, trap/mret
// sequencing of mstatus/mepc/mcause, interrupt pending logic and 64-bit counters.
module csr_unit
  import csr_pkg::*;
#(
  parameter int              XLEN          = 32,
  parameter logic [XLEN-1:0] HART_ID       = '0,
  parameter logic [XLEN-1:0] MISA_VAL      = XLEN'(32'h4000_0100),
  parameter logic [XLEN-1:0] MVENDORID_VAL = '0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  csr_unit_if.slave       bus,
  input  logic            instret_i,
  input  logic            trap_i,
  input  logic            mret_i,
  input  logic [XLEN-1:0] trap_cause_i,
  input  logic [XLEN-1:0] trap_pc_i,
  input  logic            irq_ext_i,
  input  logic            irq_timer_i,
  output logic [XLEN-1:0] mtvec_o,
  output logic [XLEN-1:0] mepc_o,
  output logic            irq_pending_o
);

  logic            mstatus_mie, mstatus_mpie;
  logic            mie_meie, mie_mtie;
  logic            mip_meip, mip_mtip;
  logic [XLEN-3:0] mtvec_base, mepc_base;
  logic [2:0]      mcounteren;
  logic            inhibit_cy, inhibit_ir;
  logic [XLEN-1:0] mcause;
  logic [63:0]     mcycle, minstret;

  logic [XLEN-1:0] rdata_p1;
  logic            vld_p1, illegal_p1;

  csr_op_e         op;
  logic [11:0]     addr;
  logic [XLEN-1:0] wdata;
  logic [XLEN-1:0] rd_val, new_val;
  logic [63:0]     new_val64;
  logic            hit, ro, illegal, acc_ok, wr_any;
  logic            wr_mstatus, wr_mie, wr_mtvec, wr_mcounteren, wr_mcountinhibit;
  logic            wr_mepc, wr_mcause, wr_mcycle, wr_mcycleh, wr_minstret, wr_minstreth;
  logic            cyc_wr_hi, ins_wr_hi;
  logic [31:0]     cnt_wdata_lo, cnt_wdata_hi;

  function automatic logic [XLEN-1:0] apply_op(input csr_op_e o, input logic [XLEN-1:0] old,
                                               input logic [XLEN-1:0] wd);
    case (o)
      CSR_OP_WRITE: return wd;
      CSR_OP_SET:   return old | wd;
      CSR_OP_CLEAR: return old & ~wd;
      default:      return old;
    endcase
  endfunction

  assign op    = csr_op_e'(bus.csr_op_i);
  assign addr  = bus.csr_addr_i;
  assign wdata = bus.csr_wdata_i;

  // Stage p0: address decode and architectural read value.
  always_comb begin
    rd_val = '0;
    hit    = 1'b1;
    ro     = 1'b0;
    case (addr)
      CSR_MISA:      begin rd_val = MISA_VAL;      ro = 1'b1; end
      CSR_MVENDORID: begin rd_val = MVENDORID_VAL; ro = 1'b1; end
      CSR_MARCHID:   ro = 1'b1;
      CSR_MIMPID:    ro = 1'b1;
      CSR_MHARTID:   begin rd_val = HART_ID;       ro = 1'b1; end
      CSR_MSTATUS: begin
        rd_val[MSTATUS_MIE]                   = mstatus_mie;
        rd_val[MSTATUS_MPIE]                  = mstatus_mpie;
        rd_val[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
      end
      CSR_MIE: begin
        rd_val[MIE_MEIE] = mie_meie;
        rd_val[MIE_MTIE] = mie_mtie;
      end
      CSR_MTVEC:      rd_val = {mtvec_base, 2'b00};
      CSR_MCOUNTEREN: rd_val[2:0] = mcounteren;
      CSR_MCOUNTINHIBIT: begin
        rd_val[MCNTINH_CY] = inhibit_cy;
        rd_val[MCNTINH_IR] = inhibit_ir;
      end
      CSR_MEPC:   rd_val = {mepc_base, 2'b00};
      CSR_MCAUSE: rd_val = mcause;
      CSR_MIP: begin
        rd_val[MIP_MEIP] = mip_meip;
        rd_val[MIP_MTIP] = mip_mtip;
      end
      CSR_MCYCLE:   rd_val = mcycle[XLEN-1:0];
      CSR_MINSTRET: rd_val = minstret[XLEN-1:0];
      CSR_MCYCLEH: begin
        if (XLEN == 32) rd_val = XLEN'(mcycle[63:32]);
        else            hit    = 1'b0;
      end
      CSR_MINSTRETH: begin
        if (XLEN == 32) rd_val = XLEN'(minstret[63:32]);
        else            hit    = 1'b0;
      end
      default: hit = 1'b0;
    endcase
  end

  // A set/clear with a zero mask is a plain read, which is allowed on read-only CSRs.
  assign illegal = !hit || (ro && (op == CSR_OP_WRITE || (op != CSR_OP_READ && wdata != '0)));
  assign acc_ok  = bus.csr_en_i && !illegal;
  assign wr_any  = acc_ok && op != CSR_OP_READ && !ro;
  assign new_val = apply_op(op, rd_val, wdata);

  assign wr_mstatus       = wr_any && addr == CSR_MSTATUS;
  assign wr_mie           = wr_any && addr == CSR_MIE;
  assign wr_mtvec         = wr_any && addr == CSR_MTVEC;
  assign wr_mcounteren    = wr_any && addr == CSR_MCOUNTEREN;
  assign wr_mcountinhibit = wr_any && addr == CSR_MCOUNTINHIBIT;
  assign wr_mepc          = wr_any && addr == CSR_MEPC;
  assign wr_mcause        = wr_any && addr == CSR_MCAUSE;
  assign wr_mcycle        = wr_any && addr == CSR_MCYCLE;
  assign wr_mcycleh       = wr_any && addr == CSR_MCYCLEH;
  assign wr_minstret      = wr_any && addr == CSR_MINSTRET;
  assign wr_minstreth     = wr_any && addr == CSR_MINSTRETH;

  // RV32 writes one counter half per access; RV64 writes both halves at once.
  assign new_val64    = 64'(new_val);
  assign cnt_wdata_lo = new_val64[31:0];
  assign cnt_wdata_hi = (XLEN == 32) ? new_val64[31:0] : new_val64[63:32];
  assign cyc_wr_hi    = (XLEN == 32) ? wr_mcycleh   : wr_mcycle;
  assign ins_wr_hi    = (XLEN == 32) ? wr_minstreth : wr_minstret;

  // Stage p1: architectural state update and registered access response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mie_meie     <= 1'b0;
      mie_mtie     <= 1'b0;
      mip_meip     <= 1'b0;
      mip_mtip     <= 1'b0;
      mtvec_base   <= '0;
      mepc_base    <= '0;
      mcounteren   <= '0;
      inhibit_cy   <= 1'b0;
      inhibit_ir   <= 1'b0;
      mcause       <= '0;
      rdata_p1     <= '0;
      vld_p1       <= 1'b0;
      illegal_p1   <= 1'b0;
    end else begin
      vld_p1     <= bus.csr_en_i;
      illegal_p1 <= bus.csr_en_i && illegal;
      rdata_p1   <= acc_ok ? rd_val : '0;
      mip_meip   <= irq_ext_i;
      mip_mtip   <= irq_timer_i;

      if (wr_mie) begin
        mie_meie <= new_val[MIE_MEIE];
        mie_mtie <= new_val[MIE_MTIE];
      end
      if (wr_mtvec)      mtvec_base <= new_val[XLEN-1:2];
      if (wr_mcounteren) mcounteren <= new_val[2:0];
      if (wr_mcountinhibit) begin
        inhibit_cy <= new_val[MCNTINH_CY];
        inhibit_ir <= new_val[MCNTINH_IR];
      end

      // Trap entry dominates mret and any same-cycle software write to the trap CSRs.
      if (trap_i) begin
        mepc_base    <= trap_pc_i[XLEN-1:2];
        mcause       <= trap_cause_i;
        mstatus_mpie <= mstatus_mie;
        mstatus_mie  <= 1'b0;
      end else begin
        if (wr_mepc)   mepc_base <= new_val[XLEN-1:2];
        if (wr_mcause) mcause    <= new_val;
        if (mret_i) begin
          mstatus_mie  <= mstatus_mpie;
          mstatus_mpie <= 1'b1;
        end else if (wr_mstatus) begin
          mstatus_mie  <= new_val[MSTATUS_MIE];
          mstatus_mpie <= new_val[MSTATUS_MPIE];
        end
      end
    end
  end

  csr_counter64 u_mcycle (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .inhibit_i  (inhibit_cy),
    .inc_i      (1'b1),
    .wr_lo_i    (wr_mcycle),
    .wr_hi_i    (cyc_wr_hi),
    .wdata_lo_i (cnt_wdata_lo),
    .wdata_hi_i (cnt_wdata_hi),
    .count_o    (mcycle)
  );

  csr_counter64 u_minstret (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .inhibit_i  (inhibit_ir),
    .inc_i      (instret_i),
    .wr_lo_i    (wr_minstret),
    .wr_hi_i    (ins_wr_hi),
    .wdata_lo_i (cnt_wdata_lo),
    .wdata_hi_i (cnt_wdata_hi),
    .count_o    (minstret)
  );

  assign bus.csr_rdata_o   = rdata_p1;
  assign bus.csr_valid_o   = vld_p1;
  assign bus.csr_illegal_o = illegal_p1;

  assign mtvec_o       = {mtvec_base, 2'b00};
  assign mepc_o        = {mepc_base, 2'b00};
  assign irq_pending_o = mstatus_mie && ((mip_meip && mie_meie) || (mip_mtip && mie_mtie));

endmodule
